// File: rtl/game_pkg.sv
// Shared screen geometry, coordinate widths and the draw sequencer state type
// for the stacking-game VGA path.
package game_pkg;

    localparam int unsigned X_W       = 8;
    localparam int unsigned Y_W       = 7;
    localparam int unsigned SCR_W     = 160;
    localparam int unsigned SCR_H     = 120;
    localparam logic [2:0]  BG_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ERASE,
        S_DRAW,
        S_DONE
    } draw_state_e;

endpackage

// File: rtl/rect_scanner.sv
// Raster 2-D counter: cx sweeps 0..i_max_x inside cy 0..i_max_y.
// Load has priority over run; o_last flags the final pixel of the rectangle.
module rect_scanner #(
    parameter int unsigned CX_W = 8,
    parameter int unsigned CY_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_run,
    input  logic [CX_W-1:0] i_max_x,
    input  logic [CY_W-1:0] i_max_y,
    output logic [CX_W-1:0] o_cx,
    output logic [CY_W-1:0] o_cy,
    output logic            o_last
);

    logic [CX_W-1:0] r_cx;
    logic [CY_W-1:0] r_cy;
    logic            w_row_end;

    assign w_row_end = (r_cx == i_max_x);
    assign o_last    = w_row_end && (r_cy == i_max_y);
    assign o_cx      = r_cx;
    assign o_cy      = r_cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_load) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_run) begin
            if (w_row_end) begin
                r_cx <= '0;
                r_cy <= r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_draw_ctrl.sv
// Plot-port sequencer: per frame sync either clears the whole screen or erases
// the block at its old position and redraws it at the new one.
module block_draw_ctrl
    import game_pkg::*;
#(
    parameter int unsigned BLK_W     = 32,
    parameter int unsigned BLK_H     = 8,
    parameter int unsigned SCR_W     = game_pkg::SCR_W,
    parameter int unsigned SCR_H     = game_pkg::SCR_H,
    parameter logic [2:0]  BG_COLOUR = game_pkg::BG_COLOUR
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           sync,
    input  logic           draw_req,
    input  logic           clear_req,
    input  logic           erase_en,
    input  logic [X_W-1:0] new_x,
    input  logic [Y_W-1:0] new_y,
    input  logic [X_W-1:0] old_x,
    input  logic [Y_W-1:0] old_y,
    input  logic [2:0]     colour,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot,
    output logic           busy,
    output logic           done
);

    localparam logic [X_W:0] SCR_W_LIM = (X_W + 1)'(SCR_W);
    localparam logic [Y_W:0] SCR_H_LIM = (Y_W + 1)'(SCR_H);

    draw_state_e    r_state, w_next;
    logic [X_W-1:0] r_new_x, r_old_x, r_x;
    logic [Y_W-1:0] r_new_y, r_old_y, r_y;
    logic [2:0]     r_colour, r_col, w_pix_col;
    logic           r_plot, r_busy, r_done;
    logic [X_W-1:0] w_cx, w_max_x;
    logic [Y_W-1:0] w_cy, w_max_y;
    logic [X_W:0]   w_sum_x;
    logic [Y_W:0]   w_sum_y;
    logic           w_last, w_scan, w_load;

    rect_scanner #(
        .CX_W (X_W),
        .CY_W (Y_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (resetn),
        .i_load  (w_load),
        .i_run   (w_scan),
        .i_max_x (w_max_x),
        .i_max_y (w_max_y),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Acceptance is gated by busy so the done-pulse cycle also drops a sync.
    always_comb begin
        w_next  = r_state;
        w_scan  = 1'b0;
        w_max_x = X_W'(BLK_W - 1);
        w_max_y = Y_W'(BLK_H - 1);
        unique case (r_state)
            S_IDLE: begin
                if (sync && !r_busy) begin
                    if (clear_req)     w_next = S_CLEAR;
                    else if (draw_req) w_next = erase_en ? S_ERASE : S_DRAW;
                end
            end
            S_CLEAR: begin
                w_scan  = 1'b1;
                w_max_x = X_W'(SCR_W - 1);
                w_max_y = Y_W'(SCR_H - 1);
                if (w_last) w_next = S_DONE;
            end
            S_ERASE: begin
                w_scan = 1'b1;
                if (w_last) w_next = S_DRAW;
            end
            S_DRAW: begin
                w_scan = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_load = (w_next != r_state) || !w_scan;

    always_comb begin
        w_sum_x   = {1'b0, w_cx};
        w_sum_y   = {1'b0, w_cy};
        w_pix_col = BG_COLOUR;
        if (r_state == S_ERASE) begin
            w_sum_x = {1'b0, r_old_x} + {1'b0, w_cx};
            w_sum_y = {1'b0, r_old_y} + {1'b0, w_cy};
        end else if (r_state == S_DRAW) begin
            w_sum_x   = {1'b0, r_new_x} + {1'b0, w_cx};
            w_sum_y   = {1'b0, r_new_y} + {1'b0, w_cy};
            w_pix_col = r_colour;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_new_x  <= '0;
            r_new_y  <= '0;
            r_old_x  <= '0;
            r_old_y  <= '0;
            r_colour <= '0;
        end else if (r_state == S_IDLE && w_next != S_IDLE) begin
            r_new_x  <= new_x;
            r_new_y  <= new_y;
            r_old_x  <= old_x;
            r_old_y  <= old_y;
            r_colour <= colour;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
            r_plot <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_plot <= w_scan && (w_sum_x < SCR_W_LIM) && (w_sum_y < SCR_H_LIM);
            r_busy <= (w_next != S_IDLE) || (r_state == S_DONE);
            r_done <= (r_state == S_DONE);
            if (w_scan) begin
                r_x   <= w_sum_x[X_W-1:0];
                r_y   <= w_sum_y[Y_W-1:0];
                r_col <= w_pix_col;
            end
        end
    end

    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_col;
    assign vga_plot   = r_plot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
